instr_sequencer: RTL and testbench

Program sequencer for the autoencoder core. It fetches instruction words from an external instruction memory, handles loop and halt instructions itself, and issues datapath opcodes plus operand addresses one at a time to the opcode-decoding control unit directly downstream. It provides a start/busy/done handshake to the top-level controller and holds issue whenever the datapath stalls.

---
 rtl/ae_isa_pkg.sv | 38 +++
 rtl/seq_loop_ctrl.sv | 42 ++++
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ae_isa_pkg.sv
// ISA constants, instruction field positions and sequencer state encoding for the autoencoder core.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ae_isa_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_WR   = 4'b0011;
    localparam logic [3:0] OP_SEL  = 4'b0100;
    localparam logic [3:0] OP_SIG  = 4'b0101;
    localparam logic [3:0] OP_RELU = 4'b0110;
    localparam logic [3:0] OP_DSIG = 4'b0111;
    localparam logic [3:0] OP_OUT  = 4'b1000;
    localparam logic [3:0] OP_LOOP = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam int OP_LSB   = 12;
    localparam int DST_LSB  = 8;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_LSB = 0;
    localparam int TGT_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
    } seq_state_t;

    // Opcodes that are forwarded to the control unit rather than handled locally.
    function automatic logic is_dp_op(input logic [3:0] op);
        return (op <= OP_OUT) || (op == OP_NOP);
    endfunction

endpackage

// File: rtl/seq_loop_ctrl.sv
// Single-level loop counter: decides whether a LOOP instruction branches back to its target.
// Latency: take_branch is combinational on req; counter/active update on the next edge.
// Backpressure: none; a request is consumed in the cycle it is presented.
module seq_loop_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             req,
    input  logic [CNT_W-1:0] n,
    output logic             take_branch
);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;

    // First encounter arms the counter with N-1; later encounters count it down.
    assign take_branch = req && (active_q ? (cnt_q != '0) : (n != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (clear) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (req) begin
            if (active_q) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    active_q <= 1'b0;
                end
            end else if (n != '0) begin
                cnt_q    <= n - CNT_W'(1);
                active_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches instructions, resolves LOOP/HALT locally, issues datapath ops downstream.
// Latency: 3 cycles per issued instruction (fetch, decode, exec); LOOP/illegal/HALT take 2.
// Backpressure: stall holds the EXEC issue with all outputs stable; ignored in other states.
module instr_sequencer
    import ae_isa_pkg::*;
#(
    parameter int OP_WIDTH = 4,
    parameter int ADDR_W   = 4,
    parameter int PC_W     = 8,
    parameter int INSTR_W  = OP_WIDTH + 3 * ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                illegal_op,
    output logic                imem_rd_en,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    output logic                issue_valid,
    output logic [OP_WIDTH-1:0] opcode,
    output logic [ADDR_W-1:0]   dst_addr,
    output logic [ADDR_W-1:0]   src1_addr,
    output logic [ADDR_W-1:0]   src2_addr
);

    seq_state_t          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                loop_req, loop_clr, take_branch;
    logic                load_issue, set_ill, clr_ill;
    logic [OP_WIDTH-1:0] dec_op;
    logic [PC_W-1:0]     dec_tgt;

    assign dec_op    = imem_rdata[OP_LSB +: OP_WIDTH];
    assign dec_tgt   = PC_W'(imem_rdata[TGT_W-1:0]);
    assign imem_addr = pc_q;

    seq_loop_ctrl #(.CNT_W(ADDR_W)) u_loop (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (loop_clr),
        .req         (loop_req),
        .n           (imem_rdata[DST_LSB +: ADDR_W]),
        .take_branch (take_branch)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        loop_req   = 1'b0;
        loop_clr   = 1'b0;
        load_issue = 1'b0;
        set_ill    = 1'b0;
        clr_ill    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d     = '0;
                    loop_clr = 1'b1;
                    clr_ill  = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (is_dp_op(dec_op)) begin
                    load_issue = 1'b1;
                    state_d    = S_EXEC;
                end else if (dec_op == OP_LOOP) begin
                    loop_req = 1'b1;
                    pc_d     = take_branch ? dec_tgt : pc_q + PC_W'(1);
                    state_d  = S_FETCH;
                end else if (dec_op == OP_HALT) begin
                    state_d = S_DONE;
                end else begin
                    set_ill = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            illegal_op  <= 1'b0;
            imem_rd_en  <= 1'b0;
            issue_valid <= 1'b0;
            opcode      <= OP_WIDTH'(OP_NOP);
            dst_addr    <= '0;
            src1_addr   <= '0;
            src2_addr   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            busy        <= (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
            done        <= (state_d == S_DONE);
            imem_rd_en  <= (state_d == S_FETCH);
            issue_valid <= (state_d == S_EXEC);
            if (clr_ill) begin
                illegal_op <= 1'b0;
            end else if (set_ill) begin
                illegal_op <= 1'b1;
            end
            if (load_issue) begin
                opcode    <= dec_op;
                dst_addr  <= imem_rdata[DST_LSB +: ADDR_W];
                src1_addr <= imem_rdata[SRC1_LSB +: ADDR_W];
                src2_addr <= imem_rdata[SRC2_LSB +: ADDR_W];
            end else if (state_d != S_EXEC) begin
                opcode <= OP_WIDTH'(OP_NOP);
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level program interpreter produces the expected per-cycle trace,
// a negedge process compares every cycle, and directed literal expectations pin the interpreter.
module tb_instr_sequencer;

    typedef struct packed {
        logic       rd;
        logic       busy;
        logic       done;
        logic       iv;
        logic       ill;
        logic       stl;
        logic [7:0] addr;
        logic [3:0] op;
        logic [3:0] dst;
        logic [3:0] s1;
        logic [3:0] s2;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start2, stall;
    logic [15:0] rdata, rdata2;
    logic        busy, done, ill, rd, iv;
    logic [7:0]  addr;
    logic [3:0]  op, dst, s1, s2;
    logic        busy2, done2, ill2, rd2, iv2;
    logic [1:0]  addr2;
    logic [3:0]  op2, dst2, s12, s22;

    logic [15:0] mem  [256];
    logic [15:0] mem2 [4];

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .illegal_op(ill), .imem_rd_en(rd), .imem_addr(addr), .imem_rdata(rdata),
        .stall(stall), .issue_valid(iv), .opcode(op), .dst_addr(dst),
        .src1_addr(s1), .src2_addr(s2)
    );

    instr_sequencer #(.PC_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .illegal_op(ill2), .imem_rd_en(rd2), .imem_addr(addr2), .imem_rdata(rdata2),
        .stall(stall), .issue_valid(iv2), .opcode(op2), .dst_addr(dst2),
        .src1_addr(s12), .src2_addr(s22)
    );

    always @(posedge clk) if (rd)  rdata  <= mem[addr];
    always @(posedge clk) if (rd2) rdata2 <= mem2[addr2];

    logic       sel2;
    logic       o_busy, o_done, o_ill, o_rd, o_iv;
    logic [7:0] o_addr;
    logic [3:0] o_op, o_dst, o_s1, o_s2;
    always_comb begin
        o_busy = sel2 ? busy2 : busy;
        o_done = sel2 ? done2 : done;
        o_ill  = sel2 ? ill2  : ill;
        o_rd   = sel2 ? rd2   : rd;
        o_iv   = sel2 ? iv2   : iv;
        o_addr = sel2 ? {6'b0, addr2} : addr;
        o_op   = sel2 ? op2   : op;
        o_dst  = sel2 ? dst2  : dst;
        o_s1   = sel2 ? s12   : s1;
        o_s2   = sel2 ? s22   : s2;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    cyc_t tr[$];
    int   m_pc  = 0;
    bit   m_ill = 1'b0;

    function automatic cyc_t mk(input logic rd_, input logic busy_, input logic done_, input logic iv_,
                                input logic ill_, input logic stl_, input logic [7:0] a, input logic [15:0] w);
        cyc_t c;
        c.rd = rd_; c.busy = busy_; c.done = done_; c.iv = iv_; c.ill = ill_; c.stl = stl_;
        c.addr = a;
        c.op   = iv_ ? w[15:12] : 4'hF;
        c.dst  = w[11:8];
        c.s1   = w[7:4];
        c.s2   = w[3:0];
        return c;
    endfunction

    // Interprets the program one instruction at a time and lays out the cycles each one occupies.
    task automatic build(input bit use2, input int pcw, input int st_idx, input int st_len,
                         input bit fdn, input int max_cyc);
        int pc, nis, lcnt, n, mask;
        bit lact, halted;
        logic [15:0] w;
        logic [3:0]  opc;
        mask = (1 << pcw) - 1;
        tr.delete();
        tr.push_back(mk(0, 0, 0, 0, m_ill, 0, 8'(m_pc), 16'h0));
        pc = 0; m_ill = 1'b0; lact = 1'b0; lcnt = 0; nis = 0; halted = 1'b0;
        while (!halted && tr.size() < max_cyc) begin
            w = use2 ? mem2[pc] : mem[pc];
            opc = w[15:12];
            tr.push_back(mk(1, 1, 0, 0, m_ill, fdn, 8'(pc), w));
            tr.push_back(mk(0, 1, 0, 0, m_ill, fdn, 8'(pc), w));
            if (opc <= 4'd8 || opc == 4'hF) begin
                int ns;
                ns = (nis == st_idx) ? st_len : 0;
                for (int i = 0; i <= ns; i++) tr.push_back(mk(0, 1, 0, 1, m_ill, (i < ns), 8'(pc), w));
                nis++;
                pc = (pc + 1) & mask;
            end else if (opc == 4'h9) begin
                n = int'(w[11:8]);
                if (!lact) begin
                    if (n != 0) begin lcnt = n - 1; lact = 1'b1; pc = int'(w[7:0]) & mask; end
                    else pc = (pc + 1) & mask;
                end else begin
                    if (lcnt != 0) begin lcnt--; pc = int'(w[7:0]) & mask; end
                    else begin lact = 1'b0; pc = (pc + 1) & mask; end
                end
            end else if (opc == 4'hA) begin
                tr.push_back(mk(0, 0, 1, 0, m_ill, 0, 8'(pc), w));
                halted = 1'b1;
            end else begin
                m_ill = 1'b1;
                pc = (pc + 1) & mask;
            end
        end
        m_pc = pc;
        if (halted) repeat (2) tr.push_back(mk(0, 0, 0, 0, m_ill, 0, 8'(pc), 16'h0));
    endtask

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;
    int cur = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",   cur, o_busy, tr[cur].busy);
            chk("done",   cur, o_done, tr[cur].done);
            chk("rd_en",  cur, o_rd,   tr[cur].rd);
            chk("valid",  cur, o_iv,   tr[cur].iv);
            chk("illegal", cur, o_ill, tr[cur].ill);
            chk("addr",   cur, o_addr, tr[cur].addr);
            chk("opcode", cur, o_op,   tr[cur].op);
            if (tr[cur].iv) begin
                chk("dst",  cur, o_dst, tr[cur].dst);
                chk("src1", cur, o_s1,  tr[cur].s1);
                chk("src2", cur, o_s2,  tr[cur].s2);
            end
        end
    end

    // ---------------- stimulus driver ----------------
    int iss_cyc[$];
    int iss_op[$];
    int fa[$];
    int done_cyc, f1_cyc, busy_cnt;
    logic ill_c0, ill_c2;
    logic [11:0] f3;

    task automatic run(input bit use2);
        sel2 = use2;
        iss_cyc.delete(); iss_op.delete(); fa.delete();
        done_cyc = -1; f1_cyc = -1; busy_cnt = 0; f3 = '0;
        for (int k = 0; k < tr.size(); k++) begin
            cur = k;
            stall = tr[k].stl;
            if (use2) start2 = (k == 0); else start = (k == 0);
            cmp_en = 1'b1;
            @(negedge clk);
            if (o_iv) begin iss_cyc.push_back(k); iss_op.push_back(int'(o_op)); end
            if (o_done && done_cyc < 0) done_cyc = k;
            if (o_rd) fa.push_back(int'(o_addr));
            if (o_rd && o_addr == 8'd1 && f1_cyc < 0) f1_cyc = k;
            if (o_busy) busy_cnt++;
            if (k == 0) ill_c0 = o_ill;
            if (k == 2) ill_c2 = o_ill;
            if (k == 3) f3 = {o_dst, o_s1, o_s2};
            @(posedge clk); #1;
        end
        cmp_en = 1'b0; start = 1'b0; start2 = 1'b0; stall = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; start2 = 1'b0; stall = 1'b0; sel2 = 1'b0;
        rdata = '0; rdata2 = '0;
        clear_prog();
        for (int i = 0; i < 4; i++) mem2[i] = 16'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", -1, busy, 1'b0);
        chk("rst_done", -1, done, 1'b0);
        chk("rst_valid", -1, iv, 1'b0);
        chk("rst_rd_en", -1, rd, 1'b0);
        chk("rst_illegal", -1, ill, 1'b0);
        chk("rst_opcode", -1, op, 4'hF);
        chk("rst_addr", -1, addr, 8'h00);
        chk("rst_dst", -1, dst, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Straight-line: ADD, SUB, HALT
        mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'hA000;
        build(0, 8, -1, 0, 0, 1000); run(0);
        chk("sl_issues", -1, iss_cyc.size(), 2);
        chk("sl_iss0_cyc", -1, qget(iss_cyc, 0), 3);
        chk("sl_iss1_cyc", -1, qget(iss_cyc, 1), 6);
        chk("sl_iss1_op", -1, qget(iss_op, 1), 1);
        chk("sl_add_fields", -1, f3, 12'h123);
        chk("sl_done_cyc", -1, done_cyc, 9);

        // Stall of 4 cycles on the ADD issue
        build(0, 8, 0, 4, 0, 1000); run(0);
        chk("st_add_issues", -1, iss_op.find(x) with (x == 0).size(), 5);
        chk("st_last_add_cyc", -1, qget(iss_cyc, 4), 7);
        chk("st_fetch1_cyc", -1, f1_cyc, 8);
        chk("st_done_cyc", -1, done_cyc, 13);

        // Stall asserted only in FETCH/DECODE has no effect
        build(0, 8, -1, 0, 1, 1000); run(0);
        chk("fd_done_cyc", -1, done_cyc, 9);

        // Loop: MUL, LOOP N=2 -> 0, HALT
        clear_prog();
        mem[0] = 16'h2123; mem[1] = 16'h9200; mem[2] = 16'hA000;
        build(0, 8, -1, 0, 0, 1000); run(0);
        chk("lp_mul_issues", -1, iss_op.find(x) with (x == 2).size(), 3);
        chk("lp_done_cyc", -1, done_cyc, 18);
        chk("lp_illegal", -1, ill, 1'b0);

        // LOOP with N=0 falls through
        clear_prog();
        mem[0] = 16'h9005; mem[1] = 16'h0123; mem[2] = 16'hA000;
        build(0, 8, -1, 0, 0, 1000); run(0);
        chk("l0_issues", -1, iss_cyc.size(), 1);
        chk("l0_done_cyc", -1, done_cyc, 8);

        // Illegal opcode, then a fresh start clears the flag
        clear_prog();
        mem[0] = 16'hB000; mem[1] = 16'h0123; mem[2] = 16'hA000;
        build(0, 8, -1, 0, 0, 1000); run(0);
        chk("il_issues", -1, iss_cyc.size(), 1);
        chk("il_iss_op", -1, qget(iss_op, 0), 0);
        chk("il_sticky", -1, ill, 1'b1);
        chk("il_done_cyc", -1, done_cyc, 8);
        mem[0] = 16'h0123; mem[1] = 16'h1456;
        build(0, 8, -1, 0, 0, 1000); run(0);
        chk("il_before_start", -1, ill_c0, 1'b1);
        chk("il_cleared", -1, ill_c2, 1'b0);

        // Asynchronous reset during a stalled MUL issue
        clear_prog();
        mem[0] = 16'h2123; mem[1] = 16'h9200; mem[2] = 16'hA000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        stall = 1'b1;
        @(posedge clk); #1;
        chk("rx_valid_pre", -1, iv, 1'b1);
        chk("rx_opcode_pre", -1, op, 4'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("rx_opcode", -1, op, 4'hF);
        chk("rx_valid", -1, iv, 1'b0);
        chk("rx_busy", -1, busy, 1'b0);
        chk("rx_addr", -1, addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        @(posedge clk); #1;
        m_pc = 0; m_ill = 1'b0;
        build(0, 8, -1, 0, 0, 1000); run(0);
        chk("rx_rerun_done", -1, done_cyc, 18);

        // PC wrap on a 2-bit program counter with no HALT
        mem2[0] = 16'h0123; mem2[1] = 16'h1456; mem2[2] = 16'h2789; mem2[3] = 16'h0ABC;
        m_pc = 0; m_ill = 1'b0;
        build(1, 2, -1, 0, 0, 16); run(1);
        chk("wr_fetches", -1, fa.size(), 5);
        for (int i = 0; i < 5; i++) chk("wr_fetch_addr", i, qget(fa, i), (i == 4) ? 0 : i);
        chk("wr_busy_cycles", -1, busy_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
